// File: rtl/tdd_sync_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tdd_sync_pkg
//  Description : Shared types and defaults for the TDD sync pulse generator:
//                FSM state encoding, default counter widths and the
//                start-rejection reason code.
//  Revision    : 1.0  initial release
// ============================================================================
package tdd_sync_pkg;

    // Default widths for the delay/period/pulse counters and the frame counter
    localparam int unsigned CNT_W_DEF   = 32;
    localparam int unsigned FRAME_W_DEF = 16;

    // Generator FSM states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_PULSE = 2'd2,
        S_GAP   = 2'd3
    } state_e;

    // Reason a start request was refused; kept encoded so a status register
    // can expose it later without changing the check logic.
    typedef enum logic [1:0] {
        REJ_NONE         = 2'd0,
        REJ_PW_ZERO      = 2'd1,
        REJ_PERIOD_ZERO  = 2'd2,
        REJ_PERIOD_LE_PW = 2'd3
    } rej_e;

endpackage : tdd_sync_pkg
`default_nettype wire

// File: rtl/tdd_sync_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : tdd_sync_edge_det
//  Description : Multi-flop synchronizer for an asynchronous level followed
//                by a rising-edge detector producing a one-cycle pulse.
//                Shared with the receiver-side sync logic.
//  Revision    : 1.0  initial release
// ============================================================================
module tdd_sync_edge_det #(
    parameter int unsigned SYNC_DEPTH = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic async_in,
    output logic rise_pulse
);

    logic [SYNC_DEPTH-1:0] sync_q, sync_d;
    logic                  prev_q, prev_d;

    generate
        if (SYNC_DEPTH > 1) begin : g_chain
            // Shift the asynchronous level through the synchronizer chain
            always_comb sync_d = {sync_q[SYNC_DEPTH-2:0], async_in};
        end else begin : g_single
            // Degenerate single-flop capture
            always_comb sync_d = async_in;
        end
    endgenerate

    // Delayed copy of the synchronized level for edge detection
    always_comb prev_d = sync_q[SYNC_DEPTH-1];

    // Synchronizer and edge-history registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise_pulse = sync_q[SYNC_DEPTH-1] & ~prev_q;

endmodule : tdd_sync_edge_det
`default_nettype wire

// File: rtl/tdd_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tdd_sync_gen
//  Description : Master-side TDD sync pulse generator. Emits a train of
//                sync pulses (start delay, pulse width, period, frame count)
//                with busy/done/cfg_err status and a frame counter.
//                Optional build macro TDD_SYNC_GEN_EXT_ALIGN_EN adds an
//                ext_trig input; the start delay is then counted from a
//                synchronized rising edge of ext_trig instead of the start.
//  Revision    : 1.0  initial release
// ============================================================================
module tdd_sync_gen
    import tdd_sync_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned FRAME_W = FRAME_W_DEF
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               enable,
    input  logic               start,
    input  logic [CNT_W-1:0]   start_delay,
    input  logic [CNT_W-1:0]   period,
    input  logic [CNT_W-1:0]   pulse_width,
    input  logic [FRAME_W-1:0] num_frames,
`ifdef TDD_SYNC_GEN_EXT_ALIGN_EN
    input  logic               ext_trig,
`endif
    output logic               sync_out,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [FRAME_W-1:0] FRAME_ONE = FRAME_W'(1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     sh_delay_m1_q, sh_delay_m1_d;
    logic [CNT_W-1:0]     sh_pw_m1_q, sh_pw_m1_d;
    logic [CNT_W-1:0]     sh_gap_m1_q, sh_gap_m1_d;
    logic [FRAME_W-1:0]   sh_frames_q, sh_frames_d;
    logic [FRAME_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic                 sync_out_q, sync_out_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 cfg_err_q, cfg_err_d;
    rej_e                 rej;
    logic                 last_frame;

`ifdef TDD_SYNC_GEN_EXT_ALIGN_EN
    logic                 armed_q, armed_d;
    logic                 sh_delay_zero_q, sh_delay_zero_d;
    logic                 trig_rise;

    tdd_sync_edge_det #(
        .SYNC_DEPTH (2)
    ) u_trig_edge (
        .clk        (clk),
        .rstn       (rstn),
        .async_in   (ext_trig),
        .rise_pulse (trig_rise)
    );
`endif

    // Classify the live configuration inputs for a start request
    always_comb begin
        if (pulse_width == '0) begin
            rej = REJ_PW_ZERO;
        end else if (period == '0) begin
            rej = REJ_PERIOD_ZERO;
        end else if (period <= pulse_width) begin
            rej = REJ_PERIOD_LE_PW;
        end else begin
            rej = REJ_NONE;
        end
    end

    // The pulse just counted is the final one of a finite run
    assign last_frame = (sh_frames_q != '0) && (frame_cnt_q == sh_frames_q);

    // Next-state, counter and status-strobe logic
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sh_delay_m1_d = sh_delay_m1_q;
        sh_pw_m1_d    = sh_pw_m1_q;
        sh_gap_m1_d   = sh_gap_m1_q;
        sh_frames_d   = sh_frames_q;
        frame_cnt_d   = frame_cnt_q;
        done_d        = 1'b0;
        cfg_err_d     = 1'b0;
`ifdef TDD_SYNC_GEN_EXT_ALIGN_EN
        armed_d         = armed_q;
        sh_delay_zero_d = sh_delay_zero_q;
`endif

        if (!enable) begin
            // Abort wins over everything, frame count is kept for software
            state_d = S_IDLE;
            cnt_d   = '0;
`ifdef TDD_SYNC_GEN_EXT_ALIGN_EN
            armed_d = 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (rej != REJ_NONE) begin
                            cfg_err_d = 1'b1;
                        end else begin
                            // Shadow the config as "length minus one" so the
                            // counters compare directly against terminal values
                            sh_delay_m1_d = start_delay - CNT_ONE;
                            sh_pw_m1_d    = pulse_width - CNT_ONE;
                            sh_gap_m1_d   = period - pulse_width - CNT_ONE;
                            sh_frames_d   = num_frames;
                            cnt_d         = '0;
                            frame_cnt_d   = '0;
`ifdef TDD_SYNC_GEN_EXT_ALIGN_EN
                            sh_delay_zero_d = (start_delay == '0);
                            armed_d         = 1'b0;
                            state_d         = S_DELAY;
`else
                            if (start_delay == '0) begin
                                state_d     = S_PULSE;
                                frame_cnt_d = FRAME_ONE;
                            end else begin
                                state_d     = S_DELAY;
                            end
`endif
                        end
                    end
                end

                S_DELAY: begin
`ifdef TDD_SYNC_GEN_EXT_ALIGN_EN
                    if (!armed_q) begin
                        // Waiting for the external alignment edge
                        if (trig_rise) begin
                            armed_d = 1'b1;
                            cnt_d   = '0;
                            if (sh_delay_zero_q) begin
                                state_d     = S_PULSE;
                                frame_cnt_d = frame_cnt_q + FRAME_ONE;
                            end
                        end
                    end else
`endif
                    if (cnt_q == sh_delay_m1_q) begin
                        state_d     = S_PULSE;
                        cnt_d       = '0;
                        frame_cnt_d = frame_cnt_q + FRAME_ONE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                S_PULSE: begin
                    if (cnt_q == sh_pw_m1_q) begin
                        cnt_d = '0;
                        if (last_frame) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_GAP;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                S_GAP: begin
                    if (cnt_q == sh_gap_m1_q) begin
                        state_d     = S_PULSE;
                        cnt_d       = '0;
                        frame_cnt_d = frame_cnt_q + FRAME_ONE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs are registered copies of the upcoming state
        sync_out_d = (state_d == S_PULSE);
        busy_d     = (state_d != S_IDLE);
    end

    // State, counter, shadow and output registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            sh_delay_m1_q <= '0;
            sh_pw_m1_q    <= '0;
            sh_gap_m1_q   <= '0;
            sh_frames_q   <= '0;
            frame_cnt_q   <= '0;
            sync_out_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sh_delay_m1_q <= sh_delay_m1_d;
            sh_pw_m1_q    <= sh_pw_m1_d;
            sh_gap_m1_q   <= sh_gap_m1_d;
            sh_frames_q   <= sh_frames_d;
            frame_cnt_q   <= frame_cnt_d;
            sync_out_q    <= sync_out_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

`ifdef TDD_SYNC_GEN_EXT_ALIGN_EN
    // External-alignment bookkeeping registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            armed_q         <= 1'b0;
            sh_delay_zero_q <= 1'b0;
        end else begin
            armed_q         <= armed_d;
            sh_delay_zero_q <= sh_delay_zero_d;
        end
    end
`endif

    assign sync_out  = sync_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule : tdd_sync_gen
`default_nettype wire
